// File: rtl/mem_responder_if.sv
// Memory bus between the driver/monitor environment and mem_responder.
// Optional statistics signals exist only when MEM_RESPONDER_STATS_EN is defined.
interface mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  err;
  logic [7:0]            err_count;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0]           wr_count;
  logic [15:0]           rd_count;

  modport master (
    output addr, wr_en, rd_en, wdata,
    input  rdata, rvalid, err, err_count, wr_count, rd_count
  );
  modport slave (
    input  addr, wr_en, rd_en, wdata,
    output rdata, rvalid, err, err_count, wr_count, rd_count
  );
`else
  modport master (
    output addr, wr_en, rd_en, wdata,
    input  rdata, rvalid, err, err_count
  );
  modport slave (
    input  addr, wr_en, rd_en, wdata,
    output rdata, rvalid, err, err_count
  );
`endif
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: register-file memory, single-port write, pipelined read with a
// per-stage valid bit, and wr/rd collision detection with a saturating error counter.
// Optional: define MEM_RESPONDER_STATS_EN to add saturating wr_count/rd_count outputs.
module mem_responder #(
  parameter int unsigned          ADDR_WIDTH   = 2,
  parameter int unsigned          DATA_WIDTH   = 8,
  parameter int unsigned          READ_LATENCY = 1,   // legal range 1..4
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]                   mem_q [DEPTH];
  logic [READ_LATENCY-1:0]                 valid_q;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] data_q;
  logic                                    err_q;
  logic [7:0]                              err_count_q;

  logic collide;
  logic do_read;
  logic do_write;

  assign collide  = bus.wr_en & bus.rd_en;
  assign do_read  = bus.rd_en & ~bus.wr_en;
  assign do_write = bus.wr_en & ~bus.rd_en;

  // Storage: reset every entry, otherwise write on a clean (non-colliding) write request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_WIDTH'(i)] <= RESET_VALUE;
      end
    end else if (do_write) begin
      mem_q[bus.addr] <= bus.wdata;
    end
  end

  // Read pipeline: data only moves with a valid token, so the last stage holds its last result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= do_read;
      if (do_read) begin
        data_q[0] <= mem_q[bus.addr];
      end
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  // Collision strobe and saturating collision counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q       <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      err_q <= collide;
      if (collide && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign bus.rdata     = data_q[READ_LATENCY-1];
  assign bus.rvalid    = valid_q[READ_LATENCY-1];
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] wr_count_q;
  logic [15:0] rd_count_q;

  // Saturating counts of successful writes and of reads at issue time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count_q <= 16'h0000;
      rd_count_q <= 16'h0000;
    end else begin
      if (do_write && (wr_count_q != 16'hFFFF)) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
      if (do_read && (rd_count_q != 16'hFFFF)) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign bus.wr_count = wr_count_q;
  assign bus.rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (READ_LATENCY 1, 2, 3) share one
// randomized/directed stimulus stream and are scored against a behavioural memory model.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] addr = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wdata = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus1 ();
  mem_responder_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus2 ();
  mem_responder_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus3 ();

  assign bus1.addr = addr;  assign bus1.wr_en = wr_en;
  assign bus1.rd_en = rd_en; assign bus1.wdata = wdata;
  assign bus2.addr = addr;  assign bus2.wr_en = wr_en;
  assign bus2.rd_en = rd_en; assign bus2.wdata = wdata;
  assign bus3.addr = addr;  assign bus3.wr_en = wr_en;
  assign bus3.rd_en = rd_en; assign bus3.wdata = wdata;

  mem_responder #(.READ_LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  mem_responder #(.READ_LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(bus2.slave));
  mem_responder #(.READ_LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  // Reference model: memory contents plus, for the last few edges, whether a read was
  // issued there and what it snapshotted. A read issued at edge n shows up after edge
  // n+L-1, i.e. it is entry [L-1] of this history.
  logic [7:0] m_mem [4];
  logic       h_rd [4];
  logic [7:0] h_data [4];
  logic       m_err;
  int         m_errc;
  int         m_wrc;
  int         m_rdc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mem[i]  = 8'h00;
      h_rd[i]   = 1'b0;
      h_data[i] = 8'h00;
    end
    m_err  = 1'b0;
    m_errc = 0;
    m_wrc  = 0;
    m_rdc  = 0;
  endtask

  task automatic check_dut(input int lat, input logic rv, input logic [7:0] rd,
                           input logic e, input logic [7:0] ec);
    check($sformatf("L%0d rvalid", lat), 32'(rv), 32'(h_rd[lat-1]));
    if (h_rd[lat-1]) check($sformatf("L%0d rdata", lat), 32'(rd), 32'(h_data[lat-1]));
    check($sformatf("L%0d err", lat), 32'(e), 32'(m_err));
    check($sformatf("L%0d err_count", lat), 32'(ec), 32'(m_errc));
  endtask

  task automatic check_all();
    check_dut(1, bus1.rvalid, bus1.rdata, bus1.err, bus1.err_count);
    check_dut(2, bus2.rvalid, bus2.rdata, bus2.err, bus2.err_count);
    check_dut(3, bus3.rvalid, bus3.rdata, bus3.err, bus3.err_count);
`ifdef MEM_RESPONDER_STATS_EN
    check("L1 wr_count", 32'(bus1.wr_count), 32'(m_wrc));
    check("L1 rd_count", 32'(bus1.rd_count), 32'(m_rdc));
    check("L3 wr_count", 32'(bus3.wr_count), 32'(m_wrc));
    check("L3 rd_count", 32'(bus3.rd_count), 32'(m_rdc));
`endif
  endtask

  // Outputs right after (asynchronous) reset: all zero, including the held rdata.
  task automatic check_reset_outputs();
    check("rst L1 rdata", 32'(bus1.rdata), 32'h0);
    check("rst L2 rdata", 32'(bus2.rdata), 32'h0);
    check("rst L3 rdata", 32'(bus3.rdata), 32'h0);
    check_all();
  endtask

  // One clock: drive inputs, take the edge, advance the model, then score all instances.
  task automatic step(input logic [1:0] a, input logic w, input logic r, input logic [7:0] d);
    addr  = a;
    wr_en = w;
    rd_en = r;
    wdata = d;
    @(posedge clk);
    for (int i = 3; i > 0; i--) begin
      h_rd[i]   = h_rd[i-1];
      h_data[i] = h_data[i-1];
    end
    h_rd[0]   = r && !w;
    h_data[0] = m_mem[a];
    if (w && !r) m_mem[a] = d;
    m_err = w && r;
    if (w && r && m_errc < 255) m_errc++;
    if (w && !r && m_wrc < 65535) m_wrc++;
    if (r && !w && m_rdc < 65535) m_rdc++;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'd0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    model_reset();
    #2;
    check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset contents read back as zero, back-to-back.
    for (int i = 0; i < 4; i++) step(2'(i), 1'b0, 1'b1, 8'h00);
    idle(3);

    // Directed writes, then reversed back-to-back reads.
    step(2'd0, 1'b1, 1'b0, 8'hA5);
    step(2'd1, 1'b1, 1'b0, 8'h3C);
    step(2'd2, 1'b1, 1'b0, 8'hFF);
    step(2'd3, 1'b1, 1'b0, 8'h01);
    for (int i = 3; i >= 0; i--) step(2'(i), 1'b0, 1'b1, 8'h00);
    idle(3);

    // Snapshot: write right behind an in-flight read of the same entry.
    step(2'd1, 1'b0, 1'b1, 8'h00);
    step(2'd1, 1'b1, 1'b0, 8'h77);
    idle(3);
    step(2'd1, 1'b0, 1'b1, 8'h00);
    idle(3);

    // Single collision leaves memory intact.
    step(2'd2, 1'b1, 1'b1, 8'h00);
    idle(1);
    step(2'd2, 1'b0, 1'b1, 8'h00);
    idle(3);

    // Randomized traffic, including occasional collisions.
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           8'($urandom));
    end
    idle(3);

    // Saturation of the collision counter.
    for (int i = 0; i < 300; i++) step(2'($urandom_range(0, 3)), 1'b1, 1'b1, 8'($urandom));
    idle(2);
    check("err_count saturated", 32'(bus2.err_count), 32'hFF);

    // Reset one cycle after a read issue: the read must never complete.
    step(2'd1, 1'b0, 1'b1, 8'h00);
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(4);
    for (int i = 0; i < 4; i++) step(2'(i), 1'b0, 1'b1, 8'h00);
    idle(3);

    // More random traffic from a clean reset.
    for (int i = 0; i < 200; i++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
           8'($urandom));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 2-bit-address, 8-bit-data memory bus driven by the team's driver/monitor environment. It is the block that the driver clocking block's outputs (addr, wr_en, rd_en, wdata) talk to and that returns rdata.
- Holds a small register-file memory with single-port write and pipelined read of configurable latency.
- Adds a read-valid strobe and collision detection so the monitor can score transactions precisely.

Parameters:
- ADDR_WIDTH, 2, address width; depth = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 8, width of wdata, rdata and each storage entry.
- READ_LATENCY, 1, cycles from the read-issue edge to rdata/rvalid; legal range 1..4.
- RESET_VALUE, 8'h00, value loaded into every entry on reset.

Ports:
- clk  input  1  bus clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  ADDR_WIDTH  entry selected for the access.
- wr_en  input  1  write request, sampled at posedge.
- rd_en  input  1  read request, sampled at posedge.
- wdata  input  DATA_WIDTH  write data.
- rdata  output  DATA_WIDTH  read data; valid only when rvalid=1.
- rvalid  output  1  single-cycle strobe marking rdata valid.
- err  output  1  single-cycle pulse marking a collision (wr_en and rd_en both high).
- err_count  output  8  saturating count of collisions since reset.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Reset effect (immediate, no clock needed):
  - every entry = RESET_VALUE;
  - rdata = 0, rvalid = 0, err = 0, err_count = 0;
  - read pipeline flushed.
- Write (wr_en=1, rd_en=0 at posedge): mem[addr] <= wdata. No response strobe. A read issued on the next edge returns the new data.
- Read (rd_en=1, wr_en=0 at posedge T):
  - mem[addr] is captured at edge T into pipeline stage 1.
  - Data advances one stage per clk.
  - rdata = captured value and rvalid = 1 in the cycle following edge T+READ_LATENCY-1. With READ_LATENCY=1, they are registered outputs visible right after edge T.
  - rvalid is high for exactly one cycle per read.
- Read data is a snapshot: a write to the same address after edge T does not alter the in-flight result.
- Back-to-back reads on every edge are fully pipelined: one rvalid per read, in issue order, no bubbles.
- rdata holds its last valid value while rvalid=0. The bench must not rely on it.
- Collision (wr_en=1 and rd_en=1 at the same edge):
  - neither operation is performed and memory is unchanged;
  - no rvalid is generated;
  - err=1 for the following cycle;
  - err_count increments and saturates at 8'hFF.
- Idle (both low): pipeline shifts, no memory change.
- Address: only the low ADDR_WIDTH bits are used, so there is no out-of-range case.
- Reset mid-operation: in-flight reads are dropped and no rvalid follows. Writes in the reset cycle are ignored.
- Each pipeline stage carries a valid bit and a data field. No FSM is needed beyond the pipeline valid bits.

Optional Feature:
- Macro: MEM_RESPONDER_STATS_EN.
- When defined, two extra outputs are added:
  - wr_count, 16 bits: successful writes;
  - rd_count, 16 bits: successful reads, counted at issue.
- Both counters saturate at 16'hFFFF and reset to 0. Collisions count in neither.
- When not defined, these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then read addr 0..3 with READ_LATENCY=1 -> rdata=8'h00 on each of 4 consecutive rvalid pulses, err=0.
- Write 8'hA5@0, 8'h3C@1, 8'hFF@2, 8'h01@3, then back-to-back reads 3,2,1,0 -> rvalid high 4 consecutive cycles, rdata=01,FF,3C,A5.
- READ_LATENCY=3: read addr 1 (holds 8'h3C) at edge T, write 8'h77@1 at T+1 -> rvalid after edge T+2 with rdata=8'h3C. A following read of addr 1 returns 8'h77.
- wr_en=rd_en=1, addr=2, wdata=8'h00 -> err pulses 1 cycle, err_count=1, no rvalid. A later read of addr 2 returns 8'hFF.
- Issue 300 collisions -> err_count stops at 8'hFF.
- READ_LATENCY=2: issue read, assert reset one cycle later -> no rvalid ever appears. All entries read back as RESET_VALUE after release.
